serial_sub: RTL and testbench

//  Bit-serial N-bit subtractor: computes a - b - bin one bit per clock, LSB first,

---
 rtl/serial_sub_if.sv | 28 ++
 rtl/serial_sub.sv | 110 +++++++++++
 tb/tb_serial_sub.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_sub_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Handshake: the requester raises start with a, b and bin stable; the request is
// accepted at the first rising edge where the block is idle (busy=0, done=0).
// busy is high while bits are processed. done pulses for exactly one cycle when
// diff/bout become valid. diff and bout then hold until the next accepted start.
// A start seen while busy or done is dropped, not queued.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell feeds a registered borrow. The result is shifted
// into diff from the MSB side, so after WIDTH steps diff holds the full word.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub_if.slave  bus,
  output logic [1:0]   state_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic x, y, z;
  logic d_bit;
  logic borrow_nxt;

  // Full-subtractor cell on the current LSBs and the stored borrow.
  always_comb begin
    x          = a_sr_q[0];
    y          = b_sr_q[0];
    z          = borrow_q;
    d_bit      = x ^ y ^ z;
    borrow_nxt = (~x & y) | (~(x ^ y) & z);
  end

  // Next-state logic: capture on accepted start, shift WIDTH times, pulse done.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d   = bus.a;
          b_sr_d   = bus.b;
          borrow_d = bus.bin;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d            = a_sr_q >> 1;
        b_sr_d            = b_sr_q >> 1;
        diff_d            = diff_q >> 1;
        diff_d[WIDTH-1]   = d_bit;
        borrow_d          = borrow_nxt;
        cnt_d             = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          bout_d  = borrow_nxt;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_serial_sub.sv
// Testbench for serial_sub: directed cases, busy-time protection, abort,
// back-to-back operation and a random sweep at WIDTH=8 and WIDTH=1.
module tb_serial_sub;

  logic clk;
  logic rst;
  logic [1:0] state8, state1;

  int n_pass;
  int n_checks;

  serial_sub_if #(.WIDTH(8)) if8 ();
  serial_sub_if #(.WIDTH(1)) if1 ();

  serial_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8), .state_o(state8));
  serial_sub #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1), .state_o(state1));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: {bout,diff} is the (WIDTH+1)-bit wrap of a - b - bin.
  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    if (r < 0) r = r + 512;
    return 9'(r);
  endfunction

  function automatic logic [1:0] ref1(input logic a, input logic b, input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    if (r < 0) r = r + 4;
    return 2'(r);
  endfunction

  // One 8-bit operation from IDLE; checks latency, busy length, result, done width.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input string name);
    logic [8:0] exp;
    int busy_cycles;
    int done_at;
    exp = ref8(a, b, bin);
    if8.start = 1'b1; if8.a = a; if8.b = b; if8.bin = bin;
    @(posedge clk); #1;
    if8.start = 1'b0;
    busy_cycles = 0;
    done_at = -1;
    for (int i = 0; i <= 20; i++) begin
      if (if8.done) begin done_at = i; break; end
      if (if8.busy) busy_cycles++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (done_at !== 8) $display("FAIL %s latency: done after %0d edges, required 8", name, done_at);
    else n_pass++;
    n_checks++;
    if (busy_cycles !== 8) $display("FAIL %s busy_len: %0d cycles, required 8", name, busy_cycles);
    else n_pass++;
    n_checks++;
    if ({if8.bout, if8.diff} !== exp)
      $display("FAIL %s result: bout=%0b diff=%02h, required bout=%0b diff=%02h", name, if8.bout, if8.diff, exp[8], exp[7:0]);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (if8.done !== 1'b0 || if8.busy !== 1'b0)
      $display("FAIL %s done_width: done=%0b busy=%0b, required 0/0", name, if8.done, if8.busy);
    else n_pass++;
  endtask

  task automatic run_op1(input logic a, input logic b, input logic bin);
    logic [1:0] exp;
    int done_at;
    exp = ref1(a, b, bin);
    if1.start = 1'b1; if1.a = a; if1.b = b; if1.bin = bin;
    @(posedge clk); #1;
    if1.start = 1'b0;
    done_at = -1;
    for (int i = 0; i <= 10; i++) begin
      if (if1.done) begin done_at = i; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (done_at !== 1) $display("FAIL w1 latency: done after %0d edges, required 1", done_at);
    else n_pass++;
    n_checks++;
    if ({if1.bout, if1.diff} !== exp)
      $display("FAIL w1 result a=%0b b=%0b bin=%0b: got %02b, required %02b", a, b, bin, {if1.bout, if1.diff}, exp);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.bin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({if8.busy, if8.done, if8.bout, if8.diff} !== 11'd0)
      $display("FAIL reset8: busy=%0b done=%0b bout=%0b diff=%02h, required all 0", if8.busy, if8.done, if8.bout, if8.diff);
    else n_pass++;
    n_checks++;
    if ({if1.busy, if1.done, if1.bout, if1.diff} !== 4'd0)
      $display("FAIL reset1: busy=%0b done=%0b bout=%0b diff=%0b, required all 0", if1.busy, if1.done, if1.bout, if1.diff);
    else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op8(8'h5A, 8'h3C, 1'b0, "d_5a_3c");
    run_op8(8'h00, 8'h01, 1'b0, "d_00_01");
    run_op8(8'hFF, 8'hFF, 1'b1, "d_ff_ff_b");
    run_op8(8'h80, 8'h00, 1'b1, "d_80_00_b");
    // result must hold in IDLE after done
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({if8.bout, if8.diff} !== 9'h07F)
      $display("FAIL hold: got %03h, required 07f", {if8.bout, if8.diff});
    else n_pass++;
  endtask

  task automatic test_ignore_busy();
    logic [8:0] exp;
    int dones;
    exp = ref8(8'hC3, 8'h47, 1'b1);
    if8.start = 1'b1; if8.a = 8'hC3; if8.b = 8'h47; if8.bin = 1'b1;
    @(posedge clk); #1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (if8.done) begin
        dones++;
        n_checks++;
        if ({if8.bout, if8.diff} !== exp)
          $display("FAIL ignore_result: got %03h, required %03h", {if8.bout, if8.diff}, exp);
        else n_pass++;
        if8.start = 1'b0;
        break;
      end
      if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin = 1'($urandom);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (if8.done) dones++;
    end
    n_checks++;
    if (dones !== 1) $display("FAIL ignore_pulses: %0d done pulses, required 1", dones);
    else n_pass++;
  endtask

  task automatic test_abort();
    int dones;
    if8.start = 1'b1; if8.a = 8'h12; if8.b = 8'h34; if8.bin = 1'b0;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({if8.busy, if8.done, if8.bout, if8.diff} !== 11'd0)
      $display("FAIL abort_clear: busy=%0b done=%0b bout=%0b diff=%02h, required all 0", if8.busy, if8.done, if8.bout, if8.diff);
    else n_pass++;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (if8.done || if8.busy) dones++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (dones !== 0) $display("FAIL abort_quiet: %0d busy/done cycles, required 0", dones);
    else n_pass++;
    run_op8(8'hA7, 8'h19, 1'b1, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp_q[$];
    logic [8:0] exp;
    int last_done;
    int n_done;
    n_done = 0;
    last_done = -1;
    if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin = 1'($urandom);
    exp_q.push_back(ref8(if8.a, if8.b, if8.bin));
    if8.start = 1'b1;
    for (int cyc = 0; cyc < 100 && n_done < 5; cyc++) begin
      @(posedge clk); #1;
      if (if8.done) begin
        n_done++;
        exp = exp_q.pop_front();
        n_checks++;
        if ({if8.bout, if8.diff} !== exp)
          $display("FAIL b2b_result %0d: got %03h, required %03h", n_done, {if8.bout, if8.diff}, exp);
        else n_pass++;
        if (last_done >= 0) begin
          n_checks++;
          if (cyc - last_done !== 10)
            $display("FAIL b2b_interval: %0d cycles, required 10", cyc - last_done);
          else n_pass++;
        end
        last_done = cyc;
        if8.a = 8'($urandom); if8.b = 8'($urandom); if8.bin = 1'($urandom);
        exp_q.push_back(ref8(if8.a, if8.b, if8.bin));
      end
    end
    n_checks++;
    if (n_done !== 5) $display("FAIL b2b_count: %0d operations, required 5", n_done);
    else n_pass++;
    if8.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_random8();
    for (int i = 0; i < 1000; i++) begin
      run_op8(8'($urandom), 8'($urandom), 1'($urandom_range(1, 0)), "rand8");
    end
  endtask

  task automatic test_random1();
    for (int i = 0; i < 1000; i++) begin
      run_op1(1'($urandom), 1'($urandom), 1'($urandom_range(1, 0)));
    end
  endtask

  initial begin
    n_pass = 0;
    n_checks = 0;
    test_reset();
    test_directed();
    test_ignore_busy();
    test_abort();
    test_back_to_back();
    test_random8();
    test_random1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
